// File: rtl/afpm_operand_loader.sv
// afpm_operand_loader
//
// Byte-serial operand framer in front of the logarithmic approximate FP
// multiplier core. Two 8-bit beats per operand (low byte first) arrive on
// parallel A/B byte lanes. They are assembled into a pair of FP16 operands and
// offered to the core through a valid/ready handshake. A completed pair is held
// under backpressure. A half-received frame is dropped after TIMEOUT idle
// cycles.
//
// Optional feature macro: AFPM_OPERAND_CLASSIFY_EN
//   defined     -> out_flags = {a_zero, a_special, b_zero, b_special}
//   not defined -> out_flags tied to 4'b0000, no classification logic
//
// Parameters
//   TIMEOUT    idle cycles tolerated in HI before the partial frame is dropped
//              (legal range 1..255)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   byte beat present on in_a/in_b
//   in_ready   loader accepts a beat this cycle
//   in_a       operand A byte (low beat first)
//   in_b       operand B byte (low beat first)
//   out_valid  complete operand pair held
//   out_ready  core consumes the pair this cycle
//   out_a      operand A, FP16
//   out_b      operand B, FP16
//   out_flags  {a_zero, a_special, b_zero, b_special}
//   frame_err  one-cycle pulse when a partial frame is dropped
module afpm_operand_loader #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic [3:0]  out_flags,
  output logic        frame_err
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    ST_HI   = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [7:0]  r_idle;
  logic        r_frameErr;

  logic        w_loadLo;
  logic        w_loadHi;
  logic        w_timeout;
  logic        w_idleInc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LO;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // In HI a beat always wins over the timeout, so a high beat arriving on the
  // very edge the counter would expire still completes the frame.
  // In FULL the loader accepts a new low beat only on the edge the held pair
  // leaves, which gives one pair every two cycles with back-to-back beats.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    w_loadLo    = 1'b0;
    w_loadHi    = 1'b0;
    w_timeout   = 1'b0;
    w_idleInc   = 1'b0;
    case (r_state)
      ST_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_loadLo    = 1'b1;
          w_stateNext = ST_HI;
        end
      end
      ST_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_loadHi    = 1'b1;
          w_stateNext = ST_FULL;
        end else if ((r_idle + 8'd1) >= LP_TIMEOUT) begin
          w_timeout   = 1'b1;
          w_stateNext = ST_LO;
        end else begin
          w_idleInc = 1'b1;
        end
      end
      ST_FULL: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_loadLo    = 1'b1;
            w_stateNext = ST_HI;
          end else begin
            w_stateNext = ST_LO;
          end
        end
      end
      default: begin
        w_stateNext = ST_LO;
      end
    endcase
  end

  // The idle counter saturates at TIMEOUT on the dropping edge and is cleared
  // by the next accepted low beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= 16'h0000;
      r_b        <= 16'h0000;
      r_idle     <= 8'd0;
      r_frameErr <= 1'b0;
    end else begin
      r_frameErr <= w_timeout;
      if (w_loadLo) begin
        r_a[7:0] <= in_a;
        r_b[7:0] <= in_b;
      end
      if (w_loadHi) begin
        r_a[15:8] <= in_a;
        r_b[15:8] <= in_b;
      end
      if (w_loadLo) begin
        r_idle <= 8'd0;
      end else if (w_timeout) begin
        r_idle <= LP_TIMEOUT;
      end else if (w_idleInc) begin
        r_idle <= r_idle + 8'd1;
      end
    end
  end

`ifdef AFPM_OPERAND_CLASSIFY_EN
  logic [15:0] w_nextA;
  logic [15:0] w_nextB;
  logic [3:0]  r_flags;

  // Classify the operand as it will be once the high byte lands, so the flags
  // become valid together with out_valid.
  assign w_nextA = {in_a, r_a[7:0]};
  assign w_nextB = {in_b, r_b[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (w_loadHi) begin
      r_flags <= {(w_nextA[14:0] == 15'd0), (w_nextA[14:10] == 5'h1F),
                  (w_nextB[14:0] == 15'd0), (w_nextB[14:10] == 5'h1F)};
    end
  end

  assign out_flags = r_flags;
`else
  assign out_flags = 4'b0000;
`endif

  assign out_valid = (r_state == ST_FULL);
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign frame_err = r_frameErr;

endmodule
